// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding
// and a constant-foldable ceiling-log2 used to size the bit counters.
package serial_arith_pkg;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = S_IDLE,
      ST_SHIFT = S_SHIFT,
      ST_DONE  = S_DONE
   } state_e;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/Ready/Done handshake plus operand and result buses of the serial subtractor.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);

   logic             Start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Ready;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] Diff;
   logic             Bout;
   logic             Ovf;

   modport master (
      output Start, A, B,
      input  Ready, Busy, Done, Diff, Bout, Ovf
   );

   modport slave (
      input  Start, A, B,
      output Ready, Busy, Done, Diff, Bout, Ovf
   );

endinterface

// File: rtl/full_sub_bit.sv
// One-bit full subtractor cell: D = Ai - Bi - Bin, with borrow out.
module full_sub_bit (
   input  logic Ai,
   input  logic Bi,
   input  logic Bin,
   output logic D,
   output logic Bout
);

   logic w_diff_ab;

   assign w_diff_ab = Ai ^ Bi;
   assign D         = w_diff_ab ^ Bin;
   // Borrow when Bi exceeds Ai, or when they are equal and a borrow is pending.
   assign Bout      = (~Ai & Bi) | (~w_diff_ab & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one full_sub_bit cell and a borrow flop;
// results are held on the outputs until the next operation completes.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic                CLK,
   input logic                Reset_L,
   serial_subtractor_if.slave bus
);

   localparam int CW = clog2(WIDTH);

   state_e           r_state;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [WIDTH-1:0] r_acc;
   logic [CW-1:0]    r_count;
   logic             r_borrow;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;
   logic             r_ovf;
   logic             r_ready;
   logic             r_busy;
   logic             r_done;

   logic             w_d;
   logic             w_borrow_next;
   logic [WIDTH-1:0] w_acc_next;

   full_sub_bit u_cell (
      .Ai   (r_sa[0]),
      .Bi   (r_sb[0]),
      .Bin  (r_borrow),
      .D    (w_d),
      .Bout (w_borrow_next)
   );

   // New difference bit enters at the MSB, so after WIDTH steps bit 0 is the LSB.
   assign w_acc_next = {w_d, {(WIDTH-1){1'b0}}} | (r_acc >> 1);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register in this block sees pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         r_state  <= ST_IDLE;
         r_sa     <= '0;
         r_sb     <= '0;
         r_acc    <= '0;
         r_count  <= '0;
         r_borrow <= 1'b0;
         r_diff   <= '0;
         r_bout   <= 1'b0;
         r_ovf    <= 1'b0;
         r_ready  <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.Start) begin
                  r_sa     <= bus.A;
                  r_sb     <= bus.B;
                  r_acc    <= '0;
                  r_count  <= '0;
                  r_borrow <= 1'b0;
                  r_state  <= ST_SHIFT;
                  r_ready  <= 1'b0;
                  r_busy   <= 1'b1;
               end
            end
            ST_SHIFT: begin
               r_acc    <= w_acc_next;
               r_sa     <= r_sa >> 1;
               r_sb     <= r_sb >> 1;
               r_borrow <= w_borrow_next;
               if (r_count == CW'(WIDTH - 1)) begin
                  // On the last step r_sa[0]/r_sb[0] are the original sign bits.
                  r_diff  <= w_acc_next;
                  r_bout  <= w_borrow_next;
                  r_ovf   <= (r_sa[0] ^ r_sb[0]) & (w_d ^ r_sa[0]);
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_count <= r_count + 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
               r_ready <= 1'b1;
            end
            // NOTE: the unused encoding recovers to IDLE instead of locking up.
            default: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.Ready = r_ready;
   assign bus.Busy  = r_busy;
   assign bus.Done  = r_done;
   assign bus.Diff  = r_diff;
   assign bus.Bout  = r_bout;
   assign bus.Ovf   = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes arithmetic-model results,
// a negedge monitor pops and compares them whenever Done is presented.
module tb_serial_subtractor;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] diff;
      logic         bout;
      logic         ovf;
      int           done_cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t q[$];
   exp_t last;
   bit   exp_ready = 1'b0;

   serial_subtractor_if #(.WIDTH(W)) bus ();

   serial_subtractor #(.WIDTH(W)) dut (
      .CLK     (clk),
      .Reset_L (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Plain-arithmetic reference: modular difference, unsigned compare, signed range test.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int c);
      exp_t m;
      int   ua, ub, sd;
      ua         = int'(a);
      ub         = int'(b);
      sd         = int'($signed(a)) - int'($signed(b));
      m.diff     = W'(ua - ub);
      m.bout     = (ua < ub);
      m.ovf      = (sd > 127) || (sd < -128);
      m.done_cyc = c + W + 1;
      return m;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      cyc = cyc + 1;
      if (!rst_n) begin
         last      = '{diff: '0, bout: 1'b0, ovf: 1'b0, done_cyc: 0};
         exp_ready = 1'b0;
      end
      check("one_of_ready_busy_done", 32'($countones({bus.Ready, bus.Busy, bus.Done})), 32'd1);
      if (exp_ready) begin
         check("ready_after_done", 32'(bus.Ready), 32'd1);
         exp_ready = 1'b0;
      end
      if (bus.Done) begin
         if (q.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL unexpected_done at cycle %0d: Diff=%0h with no pending operation", cyc, bus.Diff);
         end else begin
            e = q.pop_front();
            check("diff", 32'(bus.Diff), 32'(e.diff));
            check("bout", 32'(bus.Bout), 32'(e.bout));
            check("ovf", 32'(bus.Ovf), 32'(e.ovf));
            check("done_latency", 32'(cyc), 32'(e.done_cyc));
            last      = e;
            exp_ready = 1'b1;
         end
      end else begin
         check("diff_hold", 32'(bus.Diff), 32'(last.diff));
         check("bout_hold", 32'(bus.Bout), 32'(last.bout));
         check("ovf_hold", 32'(bus.Ovf), 32'(last.ovf));
      end
      if (q.size() != 0 && cyc > q[0].done_cyc) begin
         e      = q.pop_front();
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL missing_done at cycle %0d: no Done, expected at cycle %0d", cyc, e.done_cyc);
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (!bus.Ready && n < 100) begin
         @(negedge clk);
         #1;
         n = n + 1;
      end
      if (!bus.Ready) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL ready_timeout at cycle %0d: Ready=%0b expected 1", cyc, bus.Ready);
      end
   endtask

   // Issue one Start pulse; returns one cycle after the accept edge with Start low.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
      wait_ready();
      bus.A     = a;
      bus.B     = b;
      bus.Start = 1'b1;
      q.push_back(model(a, b, cyc));
      @(negedge clk);
      #1;
      bus.Start = 1'b0;
      bus.A     = W'($urandom);
      bus.B     = W'($urandom);
   endtask

   task automatic pulse_ignored_start(input int delay);
      repeat (delay) @(negedge clk);
      #1;
      bus.Start = 1'b1;
      bus.A     = W'($urandom);
      bus.B     = W'($urandom);
      @(negedge clk);
      #1;
      bus.Start = 1'b0;
   endtask

   initial begin
      int n;
      int c;
      rst_n     = 1'b0;
      bus.Start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_ready", 32'(bus.Ready), 32'd1);
      check("reset_busy", 32'(bus.Busy), 32'd0);
      check("reset_diff", 32'(bus.Diff), 32'd0);
      rst_n = 1'b1;

      // Directed arithmetic corners.
      do_op(8'd5, 8'd3);
      do_op(8'd3, 8'd5);
      do_op(8'h80, 8'h01);
      do_op(8'h7F, 8'hFF);

      // Start held high across two back-to-back operations.
      wait_ready();
      bus.A     = 8'h00;
      bus.B     = 8'h00;
      bus.Start = 1'b1;
      c         = cyc;
      q.push_back(model(8'h00, 8'h00, c));
      repeat (3) @(negedge clk);
      #1;
      bus.A = 8'hFF;
      bus.B = 8'hFF;
      repeat (W - 1) @(negedge clk);
      #1;
      q.push_back(model(8'hFF, 8'hFF, cyc));
      @(negedge clk);
      #1;
      bus.Start = 1'b0;

      // Start with new operands during SHIFT must be ignored.
      do_op(8'd9, 8'd2);
      pulse_ignored_start(2);

      // Asynchronous reset in the middle of SHIFT aborts the operation.
      do_op(W'($urandom), W'($urandom));
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      q.delete();
      #1;
      check("async_reset_ready", 32'(bus.Ready), 32'd1);
      check("async_reset_busy", 32'(bus.Busy), 32'd0);
      check("async_reset_done", 32'(bus.Done), 32'd0);
      check("async_reset_diff", 32'(bus.Diff), 32'd0);
      check("async_reset_bout", 32'(bus.Bout), 32'd0);
      check("async_reset_ovf", 32'(bus.Ovf), 32'd0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      do_op(8'd10, 8'd4);

      // Randomized operations with idle gaps and stray Starts while busy.
      for (int i = 0; i < 40; i++) begin
         wait_ready();
         repeat ($urandom_range(0, 3)) @(negedge clk);
         #1;
         do_op(W'($urandom), W'($urandom));
         if ($urandom_range(0, 1) == 1) begin
            pulse_ignored_start(int'($urandom_range(0, 5)));
         end
      end

      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n = n + 1;
      end
      #1;
      check("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
